// File: rtl/latch_write_arbiter.sv
// Four-requester round-robin arbiter that drives a shared D latch with a SETUP/ENABLE/HOLD write cycle.
// All outputs registered; inputs are ignored while a transaction is in flight.
module latch_write_arbiter #(
  parameter int DW        = 8,
  parameter int EN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] data_in,
  output logic [DW-1:0]   d_out,
  output logic            en_out,
  output logic [3:0]      gnt,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;
  logic [DW-1:0] d_out_q, d_out_d;
  logic          en_q, en_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [1:0]    win;
  logic          win_vld;

  // Walk from lowest to highest priority so the highest-priority requester is assigned last.
  always_comb begin : arb
    logic [1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    d_out_d = d_out_q;
    en_d    = en_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SETUP;
          d_out_d = data_in[32'(win)*DW +: DW];
          gnt_d   = 4'b0001 << win;
          last_d  = win;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d = ENABLE;
        en_d    = 1'b1;
        cnt_d   = 4'd1;
      end
      ENABLE: begin
        if (cnt_q == 4'(EN_CYCLES)) begin
          state_d = HOLD;
          en_d    = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        gnt_d   = 4'b0000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 2'd3;
      d_out_q <= '0;
      en_q    <= 1'b0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      d_out_q <= d_out_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign d_out  = d_out_q;
  assign en_out = en_q;
  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: two instances (EN_CYCLES=1 and 4) share stimulus and are
// compared each cycle against a phase-counting transaction model, plus directed sequences.
module tb_latch_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] data_in = 32'b0;

  logic [7:0] d1, d4;
  logic       en1, en4, b1, b4, dn1, dn4;
  logic [3:0] g1, g4;
  logic [7:0] q1 = 8'h00, q4 = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  latch_write_arbiter #(.DW(8), .EN_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .d_out(d1), .en_out(en1), .gnt(g1), .busy(b1), .done(dn1));

  latch_write_arbiter #(.DW(8), .EN_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .d_out(d4), .en_out(en4), .gnt(g4), .busy(b4), .done(dn4));

  always #5 clk = ~clk;

  always_latch if (en1) q1 = d1;
  always_latch if (en4) q4 = d4;

  // Transaction model: t counts cycles since the grant (0 setup, 1..EN enable, EN+1 hold).
  bit         m_busy[2] = '{0, 0};
  int         m_t[2]    = '{0, 0};
  int         m_who[2]  = '{0, 0};
  int         m_last[2] = '{3, 3};
  logic [7:0] m_dat[2]  = '{8'h00, 8'h00};

  function automatic int en_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_step(input int i);
    int en_c;
    en_c = en_of(i);
    if (rst) begin
      m_busy[i] = 0; m_t[i] = 0; m_last[i] = 3; m_dat[i] = 8'h00;
    end else if (m_busy[i]) begin
      if (m_t[i] == en_c + 1) m_busy[i] = 0;
      else m_t[i] = m_t[i] + 1;
    end else if (req != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last[i] + k) % 4;
        if (req[c]) begin
          m_who[i] = c; m_last[i] = c; m_dat[i] = data_in[8*c +: 8];
          m_busy[i] = 1; m_t[i] = 0;
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_vec(input int i);
    int en_c;
    logic [3:0] g;
    en_c = en_of(i);
    g = m_busy[i] ? 4'(1 << m_who[i]) : 4'b0;
    return {17'b0, g, (m_busy[i] && m_t[i] >= 1 && m_t[i] <= en_c), m_busy[i],
            (m_busy[i] && m_t[i] == en_c + 1), m_dat[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_en1", {17'b0, g1, en1, b1, dn1, d1}, exp_vec(0));
      chk("model_en4", {17'b0, g4, en4, b4, dn4, d4}, exp_vec(1));
      if (m_busy[0] && m_t[0] == 2) chk("latch_q_en1", 32'(q1), 32'(m_dat[0]));
      if (m_busy[1] && m_t[1] == 5) chk("latch_q_en4", 32'(q4), 32'(m_dat[1]));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0;
    @(negedge clk);
    chk_on = 1'b1;
    chk("reset_en1", {17'b0, g1, en1, b1, dn1, d1}, 32'h0);
    chk("reset_en4", {17'b0, g4, en4, b4, dn4, d4}, 32'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int busy_n, en_n, rises, k;
    bit saw, stable, prev;

    // Sequential round-robin vectors on the EN_CYCLES=1 instance, starting from reset (last=3).
    tbl[0] = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5};
    tbl[1] = '{4'b1111, 32'h44332211, 4'b0010, 8'h22};
    tbl[2] = '{4'b1001, 32'h44332211, 4'b1000, 8'h44};
    tbl[3] = '{4'b0110, 32'h5A6B7C8D, 4'b0010, 8'h7C};
    tbl[4] = '{4'b0001, 32'h000000C3, 4'b0001, 8'hC3};
    tbl[5] = '{4'b0100, 32'h00E70000, 4'b0100, 8'hE7};

    do_reset();
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      req = tbl[r].req; data_in = tbl[r].data;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r), 32'(g1), 32'(tbl[r].gnt));
      chk($sformatf("tbl%0d_dout", r), 32'(d1), 32'(tbl[r].dout));
      chk($sformatf("tbl%0d_setup_en", r), 32'(en1), 32'h0);
      req = 4'b0;
      busy_n = 1; en_n = 0; saw = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        if (!b1) break;
        busy_n++;
        if (en1) en_n++;
        if (dn1) begin
          saw = 1;
          chk($sformatf("tbl%0d_q", r), 32'(q1), 32'(tbl[r].dout));
        end
      end
      chk($sformatf("tbl%0d_busy_cycles", r), busy_n, 3);
      chk($sformatf("tbl%0d_en_cycles", r), en_n, 1);
      chk($sformatf("tbl%0d_done_seen", r), 32'(saw), 32'h1);
    end

    // All four requesting continuously: grants 0,1,2,3,0, data valid at SETUP.
    do_reset();
    req = 4'hF; data_in = 32'h44332211;
    for (int g = 0; g < 5; g++) begin
      for (k = 0; k < 10 && g1 == 4'b0; k++) @(negedge clk);
      chk($sformatf("rr%0d_gnt", g), 32'(g1), 32'(1 << (g % 4)));
      chk($sformatf("rr%0d_dout", g), 32'(d1), ((g % 4) + 1) * 17);
      chk($sformatf("rr%0d_en", g), 32'(en1), 32'h0);
      for (k = 0; k < 10 && g1 != 4'b0; k++) @(negedge clk);
    end
    req = 4'b0;

    // Wide enable pulse on the EN_CYCLES=4 instance.
    do_reset();
    req = 4'b0100; data_in = 32'h003C0000;
    for (k = 0; k < 10 && g4 == 4'b0; k++) @(negedge clk);
    req = 4'b0;
    chk("wide_gnt", 32'(g4), 32'h4);
    chk("wide_setup_dout", 32'(d4), 32'h3C);
    chk("wide_setup_en", 32'(en4), 32'h0);
    en_n = 0; rises = 0; prev = 0; stable = 1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (!b4) break;
      if (en4) en_n++;
      if (en4 && !prev) rises++;
      prev = en4;
      if (d4 !== 8'h3C) stable = 0;
    end
    chk("wide_en_cycles", en_n, 4);
    chk("wide_en_rises", rises, 1);
    chk("wide_dout_stable", 32'(stable), 32'h1);

    // Inputs changing mid-transaction are ignored.
    do_reset();
    req = 4'b0010; data_in = 32'h00001100;
    @(negedge clk);
    @(negedge clk);
    chk("chg_enable_en", 32'(en1), 32'h1);
    req = 4'b0; data_in = 32'h0000FF00;
    @(negedge clk);
    chk("chg_done", 32'(dn1), 32'h1);
    chk("chg_dout", 32'(d1), 32'h11);
    chk("chg_gnt", 32'(g1), 32'h2);
    chk("chg_q", 32'(q1), 32'h11);

    // Reset during the second ENABLE cycle of the EN_CYCLES=4 instance.
    do_reset();
    req = 4'hF; data_in = 32'h44332211;
    @(negedge clk);
    chk("rstmid_gnt", 32'(g4), 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_en_before", 32'(en4), 32'h1);
    rst = 1'b1; req = 4'b0;
    @(negedge clk);
    chk("rstmid_outputs", {17'b0, g4, en4, b4, dn4, d4}, 32'h0);
    rst = 1'b0; req = 4'hF;
    @(negedge clk);
    chk("rstmid_next_gnt", 32'(g4), 32'h1);

    // Randomized traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      data_in = $urandom;
    end
    rst = 1'b0; req = 4'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
